// File: rtl/shift_frame_ctrl.sv
// Serial-to-parallel frame sequencer: counts d_en-qualified bits into W-bit words
// and hands each word to a consumer through a one-entry valid/ready output register.
module shift_frame_ctrl #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     d,
    input  logic                     d_en,
    output logic [W-1:0]             q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic [$clog2(W+1)-1:0]   bit_cnt
);

    localparam int CW = $clog2(W+1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_n;
    logic [W-1:0]   sr, sr_n, sr_base, shifted;
    logic [CW-1:0]  cnt_n;
    logic           capture, complete, load;

    // start discards any partial word, so the shift operates on an empty register
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = bit_cnt;
        complete = 1'b0;
        sr_base  = start ? '0 : sr;
        shifted  = MSB_FIRST ? {sr_base[W-2:0], d} : {d, sr_base[W-1:1]};
        capture  = d_en && (start || state == SHIFT);

        if (start) begin
            state_n = SHIFT;
            sr_n    = capture ? shifted : '0;
            cnt_n   = capture ? CW'(1) : '0;
        end else if (state == SHIFT && d_en) begin
            sr_n = shifted;
            if (bit_cnt == CW'(W-1)) begin
                complete = 1'b1;
                state_n  = IDLE;
                cnt_n    = '0;
            end else begin
                cnt_n = bit_cnt + CW'(1);
            end
        end

        load = complete && (!q_valid || q_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            bit_cnt <= cnt_n;
            busy    <= (state_n == SHIFT);
            if (load) begin
                q       <= shifted;
                q_valid <= 1'b1;
            end else if (complete) begin
                // slot still full and not being drained: the new word is lost
                overrun <= 1'b1;
            end else if (q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: one MSB-first and one LSB-first instance share stimulus
// and are compared against a queue-based frame model.
module tb_shift_frame_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic clk = 1'b0;
    logic rst, start, d, d_en, q_ready;
    logic [W-1:0]  q_a, q_b;
    logic          q_valid_a, q_valid_b, busy_a, busy_b, overrun_a, overrun_b;
    logic [CW-1:0] bit_cnt_a, bit_cnt_b;

    int checks   = 0;
    int failures = 0;

    // model state: bits of the frame in arrival order
    logic          m_bits[$];
    logic          m_busy, m_qv, m_ovr;
    logic [W-1:0]  m_qa, m_qb;

    shift_frame_ctrl #(.W(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .d(d), .d_en(d_en),
        .q(q_a), .q_valid(q_valid_a), .q_ready(q_ready), .busy(busy_a),
        .overrun(overrun_a), .bit_cnt(bit_cnt_a)
    );

    shift_frame_ctrl #(.W(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .d(d), .d_en(d_en),
        .q(q_b), .q_valid(q_valid_b), .q_ready(q_ready), .busy(busy_b),
        .overrun(overrun_b), .bit_cnt(bit_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bits.delete();
        m_busy = 1'b0;
        m_qv   = 1'b0;
        m_ovr  = 1'b0;
        m_qa   = '0;
        m_qb   = '0;
    endtask

    // drive one cycle of inputs, advance the model across the edge, return #1 after it
    task automatic step(input logic s, input logic dd, input logic de, input logic rdy);
        logic         old_qv;
        bit           done;
        logic [W-1:0] wa, wb;
        @(negedge clk);
        start = s; d = dd; d_en = de; q_ready = rdy;
        @(posedge clk);
        old_qv = m_qv;
        done   = 1'b0;
        if (s) begin
            m_bits.delete();
            m_busy = 1'b1;
        end
        if (m_busy && de) m_bits.push_back(dd);
        if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
                wa[W-1-i] = m_bits[i];
                wb[i]     = m_bits[i];
            end
            m_bits.delete();
            m_busy = 1'b0;
            done   = 1'b1;
            if (!old_qv || rdy) begin
                m_qa = wa;
                m_qb = wb;
                m_qv = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (!done && old_qv && rdy) m_qv = 1'b0;
        #1;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) step(i == 0, w[7-i], 1'b1, rdy);
    endtask

    task automatic async_reset();
        @(negedge clk);
        start = 1'b0; d_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        send_frame(8'hB2, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        async_reset();
        checks++;
        if ({q_a, q_valid_a, busy_a, overrun_a, bit_cnt_a, q_b, q_valid_b, busy_b, overrun_b, bit_cnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_async a: q=%h v=%b busy=%b ovr=%b cnt=%0d b: q=%h v=%b required all 0",
                     q_a, q_valid_a, busy_a, overrun_a, bit_cnt_a, q_b, q_valid_b);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if ({q_a, q_valid_a, busy_a, overrun_a, bit_cnt_a, q_b, q_valid_b, busy_b, overrun_b, bit_cnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_idle_ignore q=%h v=%b busy=%b cnt=%0d required all 0",
                     q_a, q_valid_a, busy_a, bit_cnt_a);
        end
    endtask

    task automatic test_frame_order();
        logic [7:0] w;
        w = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            step(i == 0, w[7-i], 1'b1, 1'b1);
            if (i == 6) begin
                checks++;
                if (busy_a !== 1'b1 || bit_cnt_a !== CW'(7) || q_valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_mid busy=%b cnt=%0d v=%b required 1 7 0", busy_a, bit_cnt_a, q_valid_a);
                end
            end
        end
        checks++;
        if (q_a !== 8'hB2 || q_valid_a !== 1'b1 || busy_a !== 1'b0 || bit_cnt_a !== '0) begin
            failures++;
            $display("FAIL frame_msb q=%h v=%b busy=%b cnt=%0d required b2 1 0 0", q_a, q_valid_a, busy_a, bit_cnt_a);
        end
        checks++;
        if (q_b !== 8'h4D || q_valid_b !== 1'b1 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL frame_lsb q=%h v=%b busy=%b required 4d 1 0", q_b, q_valid_b, busy_b);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (q_valid_a !== 1'b0 || q_valid_b !== 1'b0 || q_a !== 8'hB2) begin
            failures++;
            $display("FAIL frame_one_cycle va=%b vb=%b q=%h required 0 0 b2", q_valid_a, q_valid_b, q_a);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        int         k;
        w = 8'hB2;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 3 || c == 6 || c == 9) begin
                step(1'b0, 1'b1, 1'b0, 1'b1);
                checks++;
                if (busy_a !== 1'b1 || bit_cnt_a !== CW'(k) || q_valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_hold c=%0d busy=%b cnt=%0d v=%b required 1 %0d 0", c, busy_a, bit_cnt_a, q_valid_a, k);
                end
            end else begin
                step(k == 0, w[7-k], 1'b1, 1'b1);
                k++;
            end
        end
        checks++;
        if (q_a !== 8'hB2 || q_b !== 8'h4D || q_valid_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL gap_result qa=%h qb=%h v=%b busy=%b required b2 4d 1 0", q_a, q_b, q_valid_a, busy_a);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        send_frame(8'hB2, 1'b0);
        checks++;
        if (q_a !== 8'hB2 || q_valid_a !== 1'b1 || overrun_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_first q=%h v=%b ovr=%b required b2 1 0", q_a, q_valid_a, overrun_a);
        end
        send_frame(8'hFF, 1'b0);
        checks++;
        if (q_a !== 8'hB2 || q_b !== 8'h4D || q_valid_a !== 1'b1 || overrun_a !== 1'b1 || overrun_b !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun qa=%h qb=%h v=%b ovr=%b%b required b2 4d 1 11",
                     q_a, q_b, q_valid_a, overrun_a, overrun_b);
        end
        w = 8'h0F;
        for (int i = 0; i < 8; i++) step(i == 0, w[7-i], 1'b1, i == 7);
        checks++;
        if (q_a !== 8'h0F || q_b !== 8'hF0 || q_valid_a !== 1'b1 || q_valid_b !== 1'b1) begin
            failures++;
            $display("FAIL bp_same_edge qa=%h qb=%h v=%b%b required 0f f0 11", q_a, q_b, q_valid_a, q_valid_b);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (q_valid_a !== 1'b0 || q_a !== 8'h0F || overrun_a !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain v=%b q=%h ovr=%b required 0 0f 1", q_valid_a, q_a, overrun_a);
        end
    endtask

    task automatic test_restart();
        logic [4:0] p;
        logic [7:0] w;
        p = 5'b11011;
        for (int i = 0; i < 5; i++) step(i == 0, p[4-i], 1'b1, 1'b1);
        checks++;
        if (bit_cnt_a !== CW'(5) || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL restart_partial cnt=%0d busy=%b required 5 1", bit_cnt_a, busy_a);
        end
        send_frame(8'hA5, 1'b1);
        checks++;
        if (q_a !== 8'hA5 || q_b !== 8'hA5 || q_valid_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL restart_word qa=%h qb=%h v=%b busy=%b required a5 a5 1 0", q_a, q_b, q_valid_a, busy_a);
        end
        w = 8'h6A;
        for (int i = 0; i < 4; i++) step(i == 0, w[7-i], 1'b1, 1'b0);
        async_reset();
        checks++;
        if ({q_a, q_valid_a, busy_a, overrun_a, bit_cnt_a, q_b, q_valid_b, busy_b, overrun_b, bit_cnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_midframe q=%h v=%b busy=%b ovr=%b cnt=%0d required all 0",
                     q_a, q_valid_a, busy_a, overrun_a, bit_cnt_a);
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h6A, 1'b1);
        checks++;
        if (q_a !== 8'h6A || q_b !== 8'h56 || q_valid_a !== 1'b1 || overrun_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_next_frame qa=%h qb=%h v=%b ovr=%b required 6a 56 1 0", q_a, q_b, q_valid_a, overrun_a);
        end
    endtask

    task automatic test_random();
        logic [2*W+2*CW+5:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            got = {q_a, q_b, q_valid_a, q_valid_b, busy_a, busy_b, overrun_a, overrun_b, bit_cnt_a, bit_cnt_b};
            exp = {m_qa, m_qb, m_qv, m_qv, m_busy, m_busy, m_ovr, m_ovr, CW'(m_bits.size()), CW'(m_bits.size())};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random n=%0d got qa=%h qb=%h v=%b%b busy=%b%b ovr=%b%b cnt=%0d/%0d required qa=%h qb=%h v=%b busy=%b ovr=%b cnt=%0d",
                         n, q_a, q_b, q_valid_a, q_valid_b, busy_a, busy_b, overrun_a, overrun_b,
                         bit_cnt_a, bit_cnt_b, m_qa, m_qb, m_qv, m_busy, m_ovr, m_bits.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; d = 1'b0; d_en = 1'b0; q_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_frame_order();
        test_gapped();
        test_backpressure();
        test_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
